// File: rtl/tiger_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tiger_exc_ctrl
//  Description : Exception / interrupt controller beside the Tiger decode
//                stage. Holds cause/status/epc, prioritises maskable
//                interrupts (lowest index wins) over break and syscall,
//                handles eret, coprocessor reads with write bypass and
//                registered cache-flush pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tiger_exc_ctrl #(
    parameter int NUM_IRQ    = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  clear,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic                  instr_valid,
    input  logic                  is_break,
    input  logic                  is_syscall,
    input  logic                  is_eret,
    input  logic                  branch_delay,
    input  logic [DATA_WIDTH-1:0] epc_in,
    input  logic                  cop_we,
    input  logic [4:0]            cop_wnum,
    input  logic [DATA_WIDTH-1:0] cop_wdata,
    input  logic [4:0]            cop_rnum,
    output logic                  exception,
    output logic [DATA_WIDTH-1:0] cop_rdata,
    output logic [DATA_WIDTH-1:0] epc_out,
    output logic                  icache_flush,
    output logic                  dcache_flush
);

    // Coprocessor register numbers
    localparam logic [4:0] c_REG_CAUSE   = 5'd0;
    localparam logic [4:0] c_REG_STATUS  = 5'd1;
    localparam logic [4:0] c_REG_EPC     = 5'd2;
    localparam logic [4:0] c_REG_CACHEOP = 5'd3;

    // ExcCode values
    localparam logic [4:0] c_EXC_INT     = 5'd0;
    localparam logic [4:0] c_EXC_SYSCALL = 5'd8;
    localparam logic [4:0] c_EXC_BREAK   = 5'd9;

    // Status bit positions
    localparam int c_STATUS_IE  = 0;
    localparam int c_STATUS_EXL = 1;
    localparam int c_IM_LSB     = 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0]    r_irq_q;
    logic [NUM_IRQ-1:0]    r_cause_ip;
    logic                  r_cause_bd;
    logic [4:0]            r_exc_code;
    logic [3:0]            r_irq_idx;
    logic [DATA_WIDTH-1:0] r_status;
    logic [DATA_WIDTH-1:0] r_epc;
    logic [DATA_WIDTH-1:0] r_cop_rdata;
    logic                  r_icache_flush;
    logic                  r_dcache_flush;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0]    w_im;
    logic [NUM_IRQ-1:0]    w_pending;
    logic                  w_take_irq;
    logic                  w_commit;
    logic                  w_eret;
    logic                  w_wr_status;
    logic                  w_wr_epc;
    logic                  w_wr_cacheop;
    logic [3:0]            w_irq_idx;
    logic [4:0]            w_exc_code;
    logic [DATA_WIDTH-1:0] w_cause;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [DATA_WIDTH-1:0] w_status_nxt;
    logic [DATA_WIDTH-1:0] w_epc_nxt;

    assign w_im       = r_status[c_IM_LSB +: NUM_IRQ];
    assign w_pending  = r_irq_q & w_im;
    assign w_take_irq = r_status[c_STATUS_IE] & ~r_status[c_STATUS_EXL] & (|w_pending);

    assign exception  = instr_valid & ~clear & (w_take_irq | is_break | is_syscall);

    // Architectural updates only happen on unstalled cycles.
    assign w_commit    = exception & ~stall;
    assign w_eret      = instr_valid & is_eret & ~exception & ~stall & ~clear;
    assign w_wr_status = cop_we & ~stall & (cop_wnum == c_REG_STATUS);
    assign w_wr_epc    = cop_we & ~stall & (cop_wnum == c_REG_EPC);
    // Cache maintenance must not be lost behind a stall.
    assign w_wr_cacheop = cop_we & (cop_wnum == c_REG_CACHEOP);

    // Lowest-index pending, unmasked interrupt line
    always_comb begin
        w_irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_irq_idx = 4'(i);
            end
        end
    end

    // ExcCode selection: interrupt > break > syscall
    always_comb begin
        if (w_take_irq) begin
            w_exc_code = c_EXC_INT;
        end else if (is_break) begin
            w_exc_code = c_EXC_BREAK;
        end else begin
            w_exc_code = c_EXC_SYSCALL;
        end
    end

    // Assemble the cause view. With more than 12 lines the IP field reaches
    // into bits 23:20; the recorded interrupt index takes those bits.
    always_comb begin
        w_cause                      = '0;
        w_cause[c_IM_LSB +: NUM_IRQ] = r_cause_ip;
        w_cause[23:20]               = r_irq_idx;
        w_cause[6:2]                 = r_exc_code;
        w_cause[DATA_WIDTH-1]        = r_cause_bd;
    end

    // Coprocessor read mux with same-cycle write bypass for status/epc
    always_comb begin
        case (cop_rnum)
            c_REG_CAUSE:  w_rd_data = w_cause;
            c_REG_STATUS: w_rd_data = r_status;
            c_REG_EPC:    w_rd_data = r_epc;
            default:      w_rd_data = '0;
        endcase
        if (cop_we && (cop_wnum == cop_rnum) &&
            ((cop_rnum == c_REG_STATUS) || (cop_rnum == c_REG_EPC))) begin
            w_rd_data = cop_wdata;
        end
    end

    // Next status: software write, then eret clears EXL, commit sets EXL last
    always_comb begin
        w_status_nxt = r_status;
        if (w_wr_status) begin
            w_status_nxt = cop_wdata;
        end
        if (w_eret) begin
            w_status_nxt[c_STATUS_EXL] = 1'b0;
        end
        if (w_commit) begin
            w_status_nxt[c_STATUS_EXL] = 1'b1;
        end
    end

    // Next epc: a committing exception overrides a software write
    always_comb begin
        w_epc_nxt = r_epc;
        if (w_wr_epc) begin
            w_epc_nxt = cop_wdata;
        end
        if (w_commit) begin
            w_epc_nxt = epc_in;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Interrupt input register; samples every cycle so a stall does not
    // delay recognition of a request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q <= '0;
        end else begin
            r_irq_q <= irq;
        end
    end

    // Cause fields: IP follows irq_q, the rest is captured at commit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause_ip <= '0;
            r_cause_bd <= 1'b0;
            r_exc_code <= '0;
            r_irq_idx  <= '0;
        end else if (!stall) begin
            r_cause_ip <= r_irq_q;
            if (w_commit) begin
                r_cause_bd <= branch_delay;
                r_exc_code <= w_exc_code;
                r_irq_idx  <= w_take_irq ? w_irq_idx : 4'd0;
            end
        end
    end

    // Status and epc registers (next values already honour stall)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= '0;
            r_epc    <= '0;
        end else begin
            r_status <= w_status_nxt;
            r_epc    <= w_epc_nxt;
        end
    end

    // Registered read data toward Ex; killed by clear or a committed exception
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cop_rdata <= '0;
        end else if (!stall) begin
            if (clear || exception) begin
                r_cop_rdata <= '0;
            end else begin
                r_cop_rdata <= w_rd_data;
            end
        end
    end

    // One-cycle cache flush pulses from a cacheop write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_icache_flush <= 1'b0;
            r_dcache_flush <= 1'b0;
        end else begin
            r_icache_flush <= w_wr_cacheop & cop_wdata[0];
            r_dcache_flush <= w_wr_cacheop & cop_wdata[1];
        end
    end

    assign cop_rdata    = r_cop_rdata;
    assign epc_out      = r_epc;
    assign icache_flush = r_icache_flush;
    assign dcache_flush = r_dcache_flush;

endmodule
`default_nettype wire

// File: doc/tiger_exc_ctrl.md
# tiger_exc_ctrl

Parametrised exception and interrupt controller for the Tiger MIPS pipeline, sitting beside the decode stage. It generalises the decode-stage cause/status/epc logic to `NUM_IRQ` maskable interrupt lines with lowest-index priority and a per-line mask. It adds an EXL nesting guard, `eret` return handling, write-to-read coprocessor bypass and registered cache-flush pulses. Decode feeds it per-instruction flags, and it returns the `exception` kill signal and the coprocessor read data for Ex.

## Interface
- `NUM_IRQ`, 6, number of interrupt request lines (1..16).
- `DATA_WIDTH`, 32, coprocessor register and PC width (≥ 24).

Ports (clock and reset first). `reset` is synchronous, active-high; the clock is `clk`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  holds all state updates and the registered outputs.
- `clear`  in  1  pipeline flush; the current instruction is killed.
- `irq`  in  NUM_IRQ  level-sensitive interrupt requests.
- `instr_valid`  in  1  decode holds a real instruction.
- `is_break`, `is_syscall`, `is_eret`  in  1 each  decoded instruction class.
- `branch_delay`  in  1  the instruction is in a branch delay slot.
- `epc_in`  in  DATA_WIDTH  restart PC supplied by branch logic.
- `cop_we`  in  1  write-back writes a coprocessor register.
- `cop_wnum`  in  5  coprocessor write register number.
- `cop_wdata`  in  DATA_WIDTH  coprocessor write data.
- `cop_rnum`  in  5  coprocessor read register number (instr[15:11]).
- `exception`  out  1  combinational; take the exception this cycle.
- `cop_rdata`  out  DATA_WIDTH  registered read data toward Ex.
- `epc_out`  out  DATA_WIDTH  current epc, the `eret` target.
- `icache_flush`, `dcache_flush`  out  1 each  one-cycle registered pulses.

## Operation
- **Register map**
  - reg 0 `cause`: bit31 BD; bits[8+NUM_IRQ-1:8] IP, read-only; bits[6:2] ExcCode. Writes are ignored.
  - reg 1 `status`: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM. Other bits are stored as written.
  - reg 2 `epc`: read/write.
  - reg 3 `cacheop`: write-only; reads return 0.
  - regs 4..31 read 0.
- `irq_q` is `irq` registered once. `cause.IP` is loaded with `irq_q` every non-stalled cycle.
- `take_irq = IE & !EXL & |(irq_q & IM)`.
- `exception = instr_valid & !clear & (take_irq | is_break | is_syscall)`.
- **Priority:** interrupt > break > syscall. ExcCode is 0 for interrupt, 9 for break, 8 for syscall.
- **Commit** occurs when `exception & !stall`:
  - `cause.BD <= branch_delay`
  - `cause.ExcCode` is set by the priority rule
  - `epc <= epc_in`
  - `EXL <= 1`
  - For interrupts, the lowest set index of `irq_q & IM` is recorded in `cause[23:20]`.
- **eret** when `instr_valid & is_eret & !exception & !stall & !clear`: `EXL <= 0`. IE is unchanged.
- **Cop write** when `cop_we & !stall` writes status or epc.
  - If a commit occurs in the same cycle, the commit wins on EXL and epc. Other status bits still take the written value.
- **cacheop write:** `icache_flush <= cop_wdata[0]` and `dcache_flush <= cop_wdata[1]` in the next cycle, for one cycle. Flush pulses are generated even during `stall`.
- **Read bypass:** if `cop_we` and `cop_wnum == cop_rnum` (reg 1 or 2) in the same cycle, `cop_rdata` takes `cop_wdata`.

## Timing
- **Reset values:** all registers, `irq_q`, `cop_rdata`, `epc_out` and both flush outputs are 0. Interrupts are therefore disabled out of reset.
- **Reset mid-operation:** reset overrides a same-cycle commit, eret or write.
- **Interrupt latency:** `irq` rising at edge N makes `take_irq` visible in cycle N+1; the commit happens at edge N+2 when unstalled.
- **cop_rdata:**
  - Updates one cycle after the read while `!stall`.
  - Holds during `stall`.
  - Goes to 0 on `clear` or a committed exception.
- **Exception during stall:** `exception` may assert combinationally, but no state changes until `stall` drops.
- **Clear:** `clear` suppresses `exception` entirely.
- **Nesting:** while EXL=1, interrupts are masked. break and syscall still commit and overwrite epc and cause.

## Test plan
1. **Reset.** Apply reset, then read regs 0..3 → all 0. A pulse on `irq[0]` causes no exception.
2. **Masked interrupt priority.**
   - Stimulus: write status = 0x0000_0501 (IE, IM0, IM2). Raise `irq[2]` and `irq[0]` together with `instr_valid`, `epc_in` = 0x400.
   - Response: `exception` asserts 1 cycle after `irq_q`. After commit, cause[23:20] = 0, ExcCode = 0, epc = 0x400, status = 0x0000_0503.
3. **syscall in delay slot.** syscall with `branch_delay` = 1 and `epc_in` = 0x1FC → cause = 0x8000_0020, epc = 0x1FC.
4. **eret.** eret after test 2 → EXL = 0, status = 0x501. With `irq[0]` still high, the next valid instruction re-triggers the exception.
5. **Stall and clear.**
   - Exception under `stall` for 3 cycles: no cause/epc change until release, then a single commit.
   - Exception with `clear` = 1: `exception` = 0 and no commit.
6. **Bypass and cacheop.**
   - Write epc = 0xABCD while reading reg 2 → `cop_rdata` = 0xABCD next cycle.
   - Write reg 3 = 0x3 → both flush pulses high for exactly one cycle.
